output_port_arbiter: RTL and testbench
======================================

// Module: output_port_arbiter
// PURPOSE
//  Round-robin, packet-locked arbiter for one crossbar output port of the star router.
//  Shares the port between NUM_REQ input ports and drives the one-hot grant vector consumed by the
//  output-port selector (grant[0] -> g00, grant[1] -> g01).
//  Holds a grant from head flit to tail flit and gates every transfer on downstream credits.
// PARAMETERS
//  NUM_REQ      2  number of requesting input ports (>=2)
//  CREDIT_DEPTH 4  downstream buffer slots; reset value and ceiling of the credit counter
//  CW           $clog2(CREDIT_DEPTH+1)  credit counter width (derived, do not override)
// PORTS
//  clk        in   1        rising-edge clock, sole clock
//  rst        in   1        synchronous, active-high reset
//  req        in   NUM_REQ  req[i]=1: input i presents a valid flit for this output
//  tail       in   NUM_REQ  tail[i]=1: flit presented by input i is a tail (head+tail = 1-flit pkt)
//  credit_in  in   1        downstream freed one slot this cycle
//  grant      out  NUM_REQ  registered one-hot grant, all-zero when idle
//  xfer       out  1        flit of granted input crosses the crossbar this cycle
//  locked     out  1        1 while a packet owns the port (state BUSY)
//  credit_cnt out  CW       current downstream credits
//  cred_err   out  1        sticky: credit_in received while credit_cnt==CREDIT_DEPTH
// BEHAVIOUR
//  Reset (clk edge with rst=1, regardless of state): grant=0, state=IDLE, rr_ptr=0,
//   credit_cnt=CREDIT_DEPTH, cred_err=0; xfer=0 because grant=0. Packet in flight is dropped.
//  FSM IDLE:
//   - If |req and credit_cnt!=0: pick first requester at or after rr_ptr (wrapping mod NUM_REQ),
//     register grant=onehot(winner), owner=winner, go BUSY.
//   - Otherwise stay IDLE with grant=0.
//   - No xfer in IDLE; grant becomes visible 1 cycle after arbitration.
//  FSM BUSY:
//   - grant held constant; xfer = req[owner] & (credit_cnt!=0), combinational.
//   - A req[owner] drop or credit_cnt==0 stalls in place; the grant is never revoked mid-packet.
//   - xfer & tail[owner]: next cycle grant=0, state=IDLE, rr_ptr=(owner+1) mod NUM_REQ.
//   - Result: one idle bubble between packets; a 1-flit packet occupies 2 cycles.
//  Round robin: rr_ptr only advances on packet completion, so a continuously requesting input wins
//   at most once per NUM_REQ packets while others request. Requests from non-owners during BUSY
//   are ignored.
//  Credits, next value:
//   - xfer only: cnt-1
//   - credit_in only: cnt+1
//   - both: unchanged
//   - credit_in at cnt==CREDIT_DEPTH (without xfer): saturate, set cred_err (cleared only by rst)
//   - Never below 0 because xfer requires cnt!=0.
//  Assertions for verification:
//   - grant is one-hot or zero.
//   - xfer implies grant!=0.
//   - credit_cnt<=CREDIT_DEPTH.
//   - grant stable while locked and no tail xfer.
// STRUCTURE
//  Shared package star_noc_pkg:
//   - NUM_PORTS default
//   - arbiter state encoding (ST_IDLE=1'b0, ST_BUSY=1'b1)
//   - CREDIT_DEPTH default
//  Sub-module rr_pick: combinational rotate-priority picker.
//   - Inputs: req[NUM_REQ], ptr.
//   - Outputs: onehot[NUM_REQ], idx, any.
//  Top holds the FSM, owner/ptr registers and credit counter.
// TESTING
//  1 Reset: rst high 2 cycles with req=2'b11 -> grant=00, credit_cnt=4, locked=0, cred_err=0.
//  2 Tie: req=11 from reset, 1-flit pkts (tail=11), credit_in pulsed on each xfer ->
//    grant 01,00,10,00,01... xfer every 2nd cycle.
//  3 Lock: input0 sends 3-flit pkt (tail on flit 3) while req[1]=1 -> grant=01 for all 3 xfers,
//    then 00, then 10.
//  4 Credit stall: CREDIT_DEPTH=4, no credit_in, input0 5-flit pkt -> 4 xfers, credit_cnt=0,
//    stall with grant held; one credit_in -> 5th xfer, then release.
//  5 Simultaneous: credit_cnt=2, xfer and credit_in same cycle -> credit_cnt stays 2;
//    credit_in at 4 -> stays 4, cred_err=1.
//  6 Mid-packet reset: rst during flit 2 of 3 -> next cycle grant=00, credit_cnt=4, rr_ptr=0;
//    req=11 then grants input0.

Source files
------------

// File: rtl/star_noc_pkg.sv
// Shared types and defaults for the star router NoC blocks.
// Holds the port count, credit depth and the output arbiter state encoding.
package star_noc_pkg;

    localparam int NUM_PORTS        = 2;
    localparam int CREDIT_DEPTH_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/output_port_arbiter_rr_pick.sv
// Rotate-priority picker: selects the first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_pick #(
    parameter int NUM_REQ = 2,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_REQ)) begin
                sum = sum - (IW+1)'(NUM_REQ);
            end
            cand = sum[IW-1:0];
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin, packet-locked arbiter for one crossbar output port.
// Holds a grant from head to tail flit and gates each transfer on downstream credits.
module output_port_arbiter
    import star_noc_pkg::*;
#(
    parameter int  NUM_REQ      = star_noc_pkg::NUM_PORTS,
    parameter int  CREDIT_DEPTH = star_noc_pkg::CREDIT_DEPTH_DEF,
    localparam int CW           = $clog2(CREDIT_DEPTH + 1),
    localparam int IW           = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] tail,
    input  logic               credit_in,
    output logic [NUM_REQ-1:0] grant,
    output logic               xfer,
    output logic               locked,
    output logic [CW-1:0]      credit_cnt,
    output logic               cred_err
);

    arb_state_e         state, state_n;
    logic [IW-1:0]      owner, owner_n;
    logic [IW-1:0]      rr_ptr, rr_ptr_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               cred_ok;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign cred_ok = (credit_cnt != '0);
    assign xfer    = (state == ST_BUSY) && req[owner] && cred_ok;
    assign locked  = (state == ST_BUSY);

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        unique case (state)
            ST_IDLE: begin
                grant_n = '0;
                if (pick_any && cred_ok) begin
                    grant_n = pick_onehot;
                    owner_n = pick_idx;
                    state_n = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // The pointer moves only on packet completion, which is what bounds starvation.
                if (xfer && tail[owner]) begin
                    grant_n  = '0;
                    state_n  = ST_IDLE;
                    rr_ptr_n = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            owner  <= owner_n;
            rr_ptr <= rr_ptr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CW'(CREDIT_DEPTH);
            cred_err   <= 1'b0;
        end else begin
            unique case ({xfer, credit_in})
                2'b10: credit_cnt <= credit_cnt - CW'(1);
                2'b01: begin
                    if (credit_cnt == CW'(CREDIT_DEPTH)) begin
                        cred_err <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + CW'(1);
                    end
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a packet-level reference model.
module tb_output_port_arbiter;

    localparam int N     = 2;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         credit_in;
    logic [N-1:0] grant;
    logic         xfer;
    logic         locked;
    logic [2:0]   credit_cnt;
    logic         cred_err;

    int errors = 0;
    int checks = 0;

    // Reference model state: who owns the port, where round robin starts, credits left.
    bit           model_on = 1'b0;
    bit           m_busy   = 1'b0;
    int           m_owner  = 0;
    int           m_ptr    = 0;
    int           m_credits = DEPTH;
    bit           m_err    = 1'b0;
    logic [N-1:0] prev_grant = '0;
    bit           prev_hold  = 1'b0;

    output_port_arbiter #(.NUM_REQ(N), .CREDIT_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .tail       (tail),
        .credit_in  (credit_in),
        .grant      (grant),
        .xfer       (xfer),
        .locked     (locked),
        .credit_cnt (credit_cnt),
        .cred_err   (cred_err)
    );

    always #5 clk = ~clk;

    // Apply inputs mid-cycle and compare every output against the model.
    task automatic drive_cycle(input logic [N-1:0] r, input logic [N-1:0] t,
                               input logic c, input logic rs);
        logic [N-1:0] eg;
        logic         ex;
        @(negedge clk);
        req = r; tail = t; credit_in = c; rst = rs;
        #1;
        if (model_on) begin
            eg = m_busy ? (N'(1) << m_owner) : '0;
            ex = m_busy && r[m_owner] && (m_credits > 0);
            checks++;
            if (grant !== eg) begin
                errors++; $display("FAIL model_grant t=%0t got=%b exp=%b", $time, grant, eg);
            end
            checks++;
            if (xfer !== ex) begin
                errors++; $display("FAIL model_xfer t=%0t got=%b exp=%b", $time, xfer, ex);
            end
            checks++;
            if (locked !== m_busy) begin
                errors++; $display("FAIL model_locked t=%0t got=%b exp=%b", $time, locked, m_busy);
            end
            checks++;
            if (credit_cnt !== 3'(m_credits)) begin
                errors++; $display("FAIL model_credit t=%0t got=%0d exp=%0d", $time, credit_cnt, m_credits);
            end
            checks++;
            if (cred_err !== m_err) begin
                errors++; $display("FAIL model_cred_err t=%0t got=%b exp=%b", $time, cred_err, m_err);
            end
            checks++;
            if (!$onehot0(grant) || (xfer && grant == '0) || credit_cnt > 3'(DEPTH)
                || (prev_hold && grant !== prev_grant)) begin
                errors++;
                $display("FAIL invariant t=%0t grant=%b xfer=%b credit=%0d prev_grant=%b hold=%b",
                         $time, grant, xfer, credit_cnt, prev_grant, prev_hold);
            end
        end
    endtask

    // Advance the model across the coming clock edge, then take the edge.
    task automatic advance();
        bit x;
        int w;
        prev_grant = grant;
        prev_hold  = locked && !rst && !(xfer && |(tail & grant));
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_credits = DEPTH; m_err = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            x = m_busy && req[m_owner] && (m_credits > 0);
            if (!m_busy) begin
                if (req != '0 && m_credits > 0) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    end
                    m_busy  = 1'b1;
                    m_owner = w;
                end
            end else if (x && tail[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
            if (x && !credit_in) begin
                m_credits--;
            end else if (!x && credit_in) begin
                if (m_credits == DEPTH) m_err = 1'b1;
                else m_credits++;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        drive_cycle('0, '0, 1'b0, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        drive_cycle(2'b11, 2'b00, 1'b0, 1'b1); advance();
        drive_cycle(2'b11, 2'b00, 1'b0, 1'b1); advance();
        drive_cycle(2'b00, 2'b00, 1'b0, 1'b0);
        checks++;
        if (grant !== 2'b00 || credit_cnt !== 3'd4 || locked !== 1'b0 || cred_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got grant=%b credit=%0d locked=%b err=%b exp 00/4/0/0",
                     grant, credit_cnt, locked, cred_err);
        end
        advance();
    endtask

    task automatic test_tie();
        logic [N-1:0] eg [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        logic         ex [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(2'b11, 2'b11, ex[i], 1'b0);
            checks++;
            if (grant !== eg[i] || xfer !== ex[i]) begin
                errors++;
                $display("FAIL tie cyc=%0d got grant=%b xfer=%b exp grant=%b xfer=%b",
                         i, grant, xfer, eg[i], ex[i]);
            end
            advance();
        end
    endtask

    task automatic test_lock();
        logic [N-1:0] eg [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
        logic         ex [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(2'b11, (i == 3) ? 2'b11 : 2'b10, 1'b0, 1'b0);
            checks++;
            if (grant !== eg[i] || xfer !== ex[i]) begin
                errors++;
                $display("FAIL lock cyc=%0d got grant=%b xfer=%b exp grant=%b xfer=%b",
                         i, grant, xfer, eg[i], ex[i]);
            end
            advance();
        end
    endtask

    task automatic test_credit_stall();
        logic [N-1:0] eg [10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        logic         ex [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]   ec [10] = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle((i < 9) ? 2'b01 : 2'b00, (i == 8) ? 2'b01 : 2'b00, (i == 7), 1'b0);
            checks++;
            if (grant !== eg[i] || xfer !== ex[i] || credit_cnt !== ec[i]) begin
                errors++;
                $display("FAIL credit_stall cyc=%0d got grant=%b xfer=%b credit=%0d exp %b/%b/%0d",
                         i, grant, xfer, credit_cnt, eg[i], ex[i], ec[i]);
            end
            advance();
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] ec [9] = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
        logic       ee [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive_cycle((i < 5) ? 2'b01 : 2'b00, (i == 4) ? 2'b01 : 2'b00,
                        (i >= 3 && i != 8), 1'b0);
            checks++;
            if (credit_cnt !== ec[i] || cred_err !== ee[i]) begin
                errors++;
                $display("FAIL simultaneous cyc=%0d got credit=%0d err=%b exp credit=%0d err=%b",
                         i, credit_cnt, cred_err, ec[i], ee[i]);
            end
            advance();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive_cycle(2'b01, 2'b01, 1'b0, 1'b0); advance();
        drive_cycle(2'b01, 2'b01, 1'b0, 1'b0); advance();
        drive_cycle(2'b11, 2'b00, 1'b0, 1'b0); advance();
        drive_cycle(2'b11, 2'b00, 1'b0, 1'b0);
        checks++;
        if (grant !== 2'b10) begin
            errors++; $display("FAIL mid_reset_pre got grant=%b exp=10", grant);
        end
        advance();
        drive_cycle(2'b11, 2'b00, 1'b0, 1'b1); advance();
        drive_cycle(2'b11, 2'b00, 1'b0, 1'b0);
        checks++;
        if (grant !== 2'b00 || credit_cnt !== 3'd4 || locked !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state got grant=%b credit=%0d locked=%b exp 00/4/0",
                     grant, credit_cnt, locked);
        end
        advance();
        drive_cycle(2'b11, 2'b00, 1'b0, 1'b0);
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL mid_reset_regrant got grant=%b exp=01", grant);
        end
        advance();
    endtask

    task automatic test_random();
        logic [N-1:0] r, t;
        logic         c, rs;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r  = N'($urandom_range(0, 3));
            t  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            c  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 99) == 0);
            drive_cycle(r, t, c, rs);
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
        test_reset();
        test_tie();
        test_lock();
        test_credit_stall();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
